// File: rtl/lru_cache_pkg.sv
// Shared encodings for the fully associative LRU cache: request opcodes and FSM states.
package lru_cache_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_INVAL = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WB   = 1'b1
  } state_e;

endpackage

// File: rtl/lru_assoc_cache_match.sv
// Parallel tag compare over the recency stack. Produces the hit index and the
// per-position enables used to promote/insert (shift down) or invalidate (shift up).
module lru_match_unit #(
  parameter int NUM_LINES = 4,
  parameter int TAG_WIDTH = 8,
  parameter int IW        = $clog2(NUM_LINES)
) (
  input  logic [NUM_LINES-1:0][TAG_WIDTH-1:0] tag_i,
  input  logic [NUM_LINES-1:0]                vld_i,
  input  logic [TAG_WIDTH-1:0]                req_tag_i,
  output logic                                hit_o,
  output logic [IW-1:0]                       idx_o,
  output logic [NUM_LINES-1:0]                dn_en_o,
  output logic [NUM_LINES-1:0]                up_en_o
);

  logic [NUM_LINES-1:0] match_oh;

  for (genvar g = 0; g < NUM_LINES; g++) begin : g_pos
    assign match_oh[g] = vld_i[g] && (tag_i[g] == req_tag_i);
    // Miss shifts every position down (insert at MRU); hit shifts only 1..k.
    assign dn_en_o[g]  = (g != 0) && (!hit_o || (IW'(g) <= idx_o));
    assign up_en_o[g]  = hit_o && (IW'(g) >= idx_o);
  end

  assign hit_o = |match_oh;

  always_comb begin
    idx_o = '0;
    for (int i = 0; i < NUM_LINES; i++)
      if (match_oh[i]) idx_o = IW'(i);
  end

endmodule

// File: rtl/lru_assoc_cache.sv
// Fully associative true-LRU cache; position 0 is MRU. Dirty-victim writeback is
// enabled by LRU_CACHE_WRITEBACK_EN, otherwise the cache runs write-through.
module lru_assoc_cache
  import lru_cache_pkg::*;
#(
  parameter int NUM_LINES   = 4,
  parameter int TAG_WIDTH   = 8,
  parameter int VALUE_WIDTH = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic [1:0]                         req_op,
  input  logic                               req_fill,
  input  logic [TAG_WIDTH-1:0]               req_tag,
  input  logic [VALUE_WIDTH-1:0]             req_wdata,
  output logic                               resp_valid,
  output logic                               resp_hit,
  output logic [VALUE_WIDTH-1:0]             resp_rdata,
  output logic                               wb_valid,
  input  logic                               wb_ready,
  output logic [TAG_WIDTH-1:0]               wb_tag,
  output logic [VALUE_WIDTH-1:0]             wb_data,
  output logic [$clog2(NUM_LINES+1)-1:0]     occupancy
);

  localparam int IW = $clog2(NUM_LINES);
  localparam int OW = $clog2(NUM_LINES+1);
`ifdef LRU_CACHE_WRITEBACK_EN
  localparam bit WB_EN = 1'b1;
`else
  localparam bit WB_EN = 1'b0;
`endif

  logic [NUM_LINES-1:0][TAG_WIDTH-1:0]   tag_q, tag_d;
  logic [NUM_LINES-1:0][VALUE_WIDTH-1:0] val_q, val_d;
  logic [NUM_LINES-1:0]                  vld_q, vld_d, dty_q, dty_d;
  logic [OW-1:0]                         occ_q, occ_d;
  logic                                  rsp_vld_q, rsp_hit_q;
  logic [VALUE_WIDTH-1:0]                rsp_rd_q;

  logic                 hit, acc, is_wr, is_inv, is_rd, victim_wb;
  logic [IW-1:0]        k;
  logic [NUM_LINES-1:0] dn_en, up_en;

  lru_match_unit #(.NUM_LINES(NUM_LINES), .TAG_WIDTH(TAG_WIDTH), .IW(IW)) u_match (
    .tag_i     (tag_q),
    .vld_i     (vld_q),
    .req_tag_i (req_tag),
    .hit_o     (hit),
    .idx_o     (k),
    .dn_en_o   (dn_en),
    .up_en_o   (up_en)
  );

  assign acc    = req_valid && req_ready;
  assign is_wr  = (req_op == OP_WRITE);
  assign is_inv = (req_op == OP_INVAL);
  assign is_rd  = !is_wr && !is_inv;

  always_comb begin
    tag_d     = tag_q;
    val_d     = val_q;
    vld_d     = vld_q;
    dty_d     = dty_q;
    occ_d     = occ_q;
    victim_wb = 1'b0;
    if (acc) begin
      if (is_inv) begin
        if (hit) begin
          for (int i = 0; i < NUM_LINES-1; i++)
            if (up_en[i]) begin
              tag_d[i] = tag_q[i+1];
              val_d[i] = val_q[i+1];
              vld_d[i] = vld_q[i+1];
              dty_d[i] = dty_q[i+1];
            end
          vld_d[NUM_LINES-1] = 1'b0;
          dty_d[NUM_LINES-1] = 1'b0;
          occ_d = occ_q - OW'(1);
        end
      end else if (is_wr || hit) begin
        for (int i = 1; i < NUM_LINES; i++)
          if (dn_en[i]) begin
            tag_d[i] = tag_q[i-1];
            val_d[i] = val_q[i-1];
            vld_d[i] = vld_q[i-1];
            dty_d[i] = dty_q[i-1];
          end
        tag_d[0] = req_tag;
        vld_d[0] = 1'b1;
        val_d[0] = is_wr ? req_wdata : val_q[k];
        dty_d[0] = is_wr ? (WB_EN && !req_fill) : dty_q[k];
        if (is_wr && !hit) begin
          if (!vld_q[NUM_LINES-1]) occ_d = occ_q + OW'(1);
          victim_wb = WB_EN && vld_q[NUM_LINES-1] && dty_q[NUM_LINES-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_q     <= '0;
      val_q     <= '0;
      vld_q     <= '0;
      occ_q     <= '0;
      rsp_vld_q <= 1'b0;
      rsp_hit_q <= 1'b0;
      rsp_rd_q  <= '0;
    end else begin
      tag_q     <= tag_d;
      val_q     <= val_d;
      vld_q     <= vld_d;
      occ_q     <= occ_d;
      rsp_vld_q <= acc;
      rsp_hit_q <= acc && hit;
      rsp_rd_q  <= (acc && hit && is_rd) ? val_q[k] : '0;
    end
  end

  assign resp_valid = rsp_vld_q;
  assign resp_hit   = rsp_hit_q;
  assign resp_rdata = rsp_rd_q;
  assign occupancy  = occ_q;

`ifdef LRU_CACHE_WRITEBACK_EN
  state_e                 st_q, st_d;
  logic [TAG_WIDTH-1:0]   wbt_q;
  logic [VALUE_WIDTH-1:0] wbd_q;

  always_comb begin
    st_d = st_q;
    case (st_q)
      ST_IDLE: if (victim_wb) st_d = ST_WB;
      ST_WB:   if (wb_ready)  st_d = ST_IDLE;
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q  <= ST_IDLE;
      dty_q <= '0;
      wbt_q <= '0;
      wbd_q <= '0;
    end else begin
      st_q  <= st_d;
      dty_q <= dty_d;
      if (victim_wb) begin
        wbt_q <= tag_q[NUM_LINES-1];
        wbd_q <= val_q[NUM_LINES-1];
      end
    end
  end

  assign req_ready = (st_q == ST_IDLE);
  assign wb_valid  = (st_q == ST_WB);
  assign wb_tag    = wbt_q;
  assign wb_data   = wbd_q;
`else
  logic unused_wb;
  assign unused_wb = wb_ready ^ (^dty_d) ^ victim_wb;
  assign dty_q     = '0;
  assign req_ready = 1'b1;
  assign wb_valid  = 1'b0;
  assign wb_tag    = '0;
  assign wb_data   = '0;
`endif

endmodule

// File: tb/tb_lru_assoc_cache.sv
// Directed bench for lru_assoc_cache; the writeback section follows LRU_CACHE_WRITEBACK_EN.
module tb_lru_assoc_cache;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_fill = 1'b0, wb_ready = 1'b1;
  logic [1:0]  req_op = 2'd0;
  logic [7:0]  req_tag = 8'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        req_ready, resp_valid, resp_hit, wb_valid;
  logic [31:0] resp_rdata, wb_data;
  logic [7:0]  wb_tag;
  logic [2:0]  occupancy;

  int n_chk = 0, n_fail = 0;

  lru_assoc_cache #(.NUM_LINES(4), .TAG_WIDTH(8), .VALUE_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_fill(req_fill), .req_tag(req_tag), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_hit(resp_hit), .resp_rdata(resp_rdata), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_tag(wb_tag), .wb_data(wb_data), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_rst_vals(input string nm);
    chk({nm, "_rdy"},  req_ready, 1);
    chk({nm, "_rvld"}, resp_valid, 0);
    chk({nm, "_rhit"}, resp_hit, 0);
    chk({nm, "_rdat"}, resp_rdata, 0);
    chk({nm, "_wbv"},  wb_valid, 0);
    chk({nm, "_wbt"},  wb_tag, 0);
    chk({nm, "_wbd"},  wb_data, 0);
    chk({nm, "_occ"},  occupancy, 0);
  endtask

  // Issue one request, then check the registered response and occupancy.
  task automatic do_req(input logic [1:0] op, input logic fill, input logic [7:0] tag,
                        input logic [31:0] wd, input logic exp_hit, input logic [31:0] exp_rd,
                        input logic [2:0] exp_occ, input string nm);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_fill = fill; req_tag = tag; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) chk({nm, "_ready_timeout"}, 0, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_vld"}, resp_valid, 1);
    chk({nm, "_hit"}, resp_hit, exp_hit);
    chk({nm, "_rd"},  resp_rdata, exp_rd);
    chk({nm, "_occ"}, occupancy, exp_occ);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_rst_vals("reset");
    rst = 1'b1;

    do_req(2'd0, 0, 8'h11, 0, 0, 0, 0, "rd_empty");
    @(negedge clk);
    chk("resp_pulse", resp_valid, 0);

    // Clean fills 01..04 -> stack [04,03,02,01]
    for (int i = 1; i <= 4; i++)
      do_req(2'd1, 1, 8'(i), 32'hA0 + 32'(i), 0, 0, 3'(i), "fill");
    do_req(2'd0, 0, 8'h01, 0, 1, 32'hA1, 4, "rd_01");          // [01,04,03,02]
    do_req(2'd1, 1, 8'h05, 32'hA5, 0, 0, 4, "fill_05");        // evicts 02 -> [05,01,04,03]
    chk("silent_evict_wbv", wb_valid, 0);
    chk("silent_evict_rdy", req_ready, 1);
    do_req(2'd0, 0, 8'h02, 0, 0, 0, 4, "rd_02_gone");
    do_req(2'd0, 0, 8'h01, 0, 1, 32'hA1, 4, "rd_01_again");    // [01,05,04,03]
    do_req(2'd2, 0, 8'h03, 0, 1, 0, 3, "inval_03");            // [01,05,04]
    chk("inval_wbv", wb_valid, 0);
    do_req(2'd1, 1, 8'h06, 32'hB6, 0, 0, 4, "fill_06");        // [06,01,05,04]
    do_req(2'd0, 0, 8'h04, 0, 1, 32'hA4, 4, "rd_04_kept");     // [04,06,01,05]
    do_req(2'd2, 0, 8'h77, 0, 0, 0, 4, "inval_miss");
    do_req(2'd0, 0, 8'h05, 0, 1, 32'hA5, 4, "rd_05");          // [05,04,06,01]
    do_req(2'd1, 0, 8'h06, 32'hC6, 1, 0, 4, "wr_hit_06");      // [06,05,04,01]
    do_req(2'd0, 0, 8'h06, 0, 1, 32'hC6, 4, "rd_06");
    do_req(2'd3, 0, 8'h04, 0, 1, 32'hA4, 4, "rsvd_as_rd");     // [04,06,05,01]

`ifdef LRU_CACHE_WRITEBACK_EN
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    wb_ready = 1'b0;
    for (int i = 1; i <= 4; i++)
      do_req(2'd1, 0, 8'(i), 32'hD0 + 32'(i), 0, 0, 3'(i), "dirty_wr");
    do_req(2'd1, 0, 8'h09, 32'hD9, 0, 0, 4, "wr_09");          // victim 01 dirty
    chk("wb0_vld", wb_valid, 1);
    chk("wb0_tag", wb_tag, 8'h01);
    chk("wb0_data", wb_data, 32'hD1);
    chk("wb0_rdy", req_ready, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("wb_hold_vld", wb_valid, 1);
      chk("wb_hold_rdy", req_ready, 0);
      chk("wb_hold_tag", wb_tag, 8'h01);
      chk("wb_hold_data", wb_data, 32'hD1);
    end
    wb_ready = 1'b1;
    @(negedge clk);
    chk("wb_done_vld", wb_valid, 0);
    chk("wb_done_rdy", req_ready, 1);
    wb_ready = 1'b0;
    do_req(2'd1, 0, 8'h0A, 32'hDA, 0, 0, 4, "wr_0a");          // victim 02 dirty
    chk("wb1_vld", wb_valid, 1);
    chk("wb1_tag", wb_tag, 8'h02);
    @(negedge clk);
    rst = 1'b0;
    #1 chk_rst_vals("rst_in_wb");
    @(negedge clk);
    rst = 1'b1;
    wb_ready = 1'b1;
    do_req(2'd0, 0, 8'h04, 0, 0, 0, 0, "rd_after_rst");
`else
    // Write-through: dirty-looking evictions stay silent.
    for (int i = 0; i < 3; i++) begin
      do_req(2'd1, 0, 8'h21 + 8'(i), 32'hE0 + 32'(i), 0, 0, 4, "wt_evict");
      chk("wt_wbv", wb_valid, 0);
      chk("wt_rdy", req_ready, 1);
    end
    do_req(2'd0, 0, 8'h06, 0, 0, 0, 4, "wt_06_gone");
    chk("wt_wbt", wb_tag, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
